// File: rtl/hvsync_decoder_pkg.sv
// Shared definitions for the VGA sync decoder: counter widths, lock FSM states
// and the default timing constants it has in common with the sync generator.
package hvsync_decoder_pkg;

   localparam int unsigned H_CNT_W   = 11;
   localparam int unsigned V_CNT_W   = 10;
   localparam int unsigned PIX_Y_W   = 9;
   localparam int unsigned MATCH_W   = 8;
   localparam int unsigned ERR_CNT_W = 8;

   localparam int unsigned H_ACTIVE_START_DEF = 96;
   localparam int unsigned H_ACTIVE_DEF       = 1280;
   localparam int unsigned V_ACTIVE_START_DEF = 12;
   localparam int unsigned V_ACTIVE_DEF       = 480;
   localparam int unsigned LOCK_LINES_DEF     = 4;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } lock_state_e;

   function automatic logic [H_CNT_W-1:0] sat_inc_h(input logic [H_CNT_W-1:0] v);
      return (&v) ? v : v + H_CNT_W'(1);
   endfunction

   function automatic logic [V_CNT_W-1:0] sat_inc_v(input logic [V_CNT_W-1:0] v);
      return (&v) ? v : v + V_CNT_W'(1);
   endfunction

endpackage

// File: rtl/hvsync_decoder_edge_sync.sv
// Two-flop synchronizer for an active-low sync input followed by a registered
// falling-edge detector; the event appears three clocks after the input falls.
module hvsync_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic sync_in,
   output logic fall_evt
);

   // [0],[1] synchronize, [2] holds the previous synchronized value
   logic [2:0] sync_q, sync_d;
   logic       evt_q, evt_d;

   always_comb begin
      sync_d = {sync_q[1:0], sync_in};
      evt_d  = sync_q[2] & ~sync_q[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         evt_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         evt_q  <= evt_d;
      end
   end

   assign fall_evt = evt_q;

endmodule

// File: rtl/hvsync_decoder.sv
// Recovers pixel position, line/frame length and lock status from an external
// active-low hsync/vsync pair. Define HVSYNC_DEC_ERRCNT_EN to build the err_cnt counter.
module hvsync_decoder
   import hvsync_decoder_pkg::*;
#(
   parameter int unsigned H_ACTIVE_START = H_ACTIVE_START_DEF,
   parameter int unsigned H_ACTIVE       = H_ACTIVE_DEF,
   parameter int unsigned V_ACTIVE_START = V_ACTIVE_START_DEF,
   parameter int unsigned V_ACTIVE       = V_ACTIVE_DEF,
   parameter int unsigned LOCK_LINES     = LOCK_LINES_DEF
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 vga_h_sync,
   input  logic                 vga_v_sync,
   output logic [H_CNT_W-1:0]   pix_x,
   output logic [PIX_Y_W-1:0]   pix_y,
   output logic                 in_display,
   output logic                 locked,
   output logic [H_CNT_W-1:0]   line_len,
   output logic [V_CNT_W-1:0]   frame_len,
   output logic                 sync_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   logic h_evt, v_evt;

   hvsync_edge_sync u_h_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .sync_in  (vga_h_sync),
      .fall_evt (h_evt)
   );

   hvsync_edge_sync u_v_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .sync_in  (vga_v_sync),
      .fall_evt (v_evt)
   );

   logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d;
   logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d;
   logic [H_CNT_W-1:0] line_len_q, line_len_d;
   logic [V_CNT_W-1:0] frame_len_q, frame_len_d;
   logic [MATCH_W-1:0] match_q, match_d;
   lock_state_e        state_q, state_d;
   logic               sync_err_q, sync_err_d;
   logic               in_display_q, in_display_d;
   logic [H_CNT_W-1:0] pix_x_q, pix_x_d;
   logic [PIX_Y_W-1:0] pix_y_q, pix_y_d;

   logic [H_CNT_W-1:0] new_len;
   logic [31:0]        h_ext, v_ext;
   logic               h_win, v_win;

   assign locked = (state_q == LOCKED);

   always_comb begin
      new_len = sat_inc_h(h_cnt_q);
      h_ext   = 32'(h_cnt_q);
      v_ext   = 32'(v_cnt_q);
      h_win   = (h_ext >= H_ACTIVE_START) && (h_ext < H_ACTIVE_START + H_ACTIVE);
      v_win   = (v_ext >= V_ACTIVE_START) && (v_ext < V_ACTIVE_START + V_ACTIVE);

      h_cnt_d    = h_evt ? '0 : sat_inc_h(h_cnt_q);
      line_len_d = h_evt ? new_len : line_len_q;

      // vsync takes precedence when both events land in the same cycle
      v_cnt_d     = v_cnt_q;
      frame_len_d = frame_len_q;
      if (v_evt) begin
         v_cnt_d     = '0;
         frame_len_d = sat_inc_v(v_cnt_q);
      end else if (h_evt) begin
         v_cnt_d = sat_inc_v(v_cnt_q);
      end

      state_d    = state_q;
      match_d    = match_q;
      sync_err_d = 1'b0;
      case (state_q)
         SEARCH: begin
            if (h_evt) begin
               state_d = TRACK;
               match_d = '0;
            end
         end
         TRACK: begin
            if (h_evt) begin
               match_d = (new_len == line_len_q) ?
                         ((&match_q) ? match_q : match_q + MATCH_W'(1)) : '0;
            end
            if (v_evt && (32'(match_q) >= LOCK_LINES)) state_d = LOCKED;
         end
         LOCKED: begin
            if ((h_evt && (new_len != line_len_q)) || (&h_cnt_q) || (&v_cnt_q)) begin
               state_d    = SEARCH;
               match_d    = '0;
               sync_err_d = 1'b1;
            end
         end
         default: state_d = SEARCH;
      endcase

      in_display_d = locked && h_win && v_win;
      pix_x_d      = in_display_d ? (h_cnt_q - H_CNT_W'(H_ACTIVE_START)) : '0;
      pix_y_d      = in_display_d ? PIX_Y_W'(v_cnt_q - V_CNT_W'(V_ACTIVE_START)) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q      <= '0;
         v_cnt_q      <= '0;
         line_len_q   <= '0;
         frame_len_q  <= '0;
         match_q      <= '0;
         state_q      <= SEARCH;
         sync_err_q   <= 1'b0;
         in_display_q <= 1'b0;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
      end else begin
         h_cnt_q      <= h_cnt_d;
         v_cnt_q      <= v_cnt_d;
         line_len_q   <= line_len_d;
         frame_len_q  <= frame_len_d;
         match_q      <= match_d;
         state_q      <= state_d;
         sync_err_q   <= sync_err_d;
         in_display_q <= in_display_d;
         pix_x_q      <= pix_x_d;
         pix_y_q      <= pix_y_d;
      end
   end

   assign pix_x      = pix_x_q;
   assign pix_y      = pix_y_q;
   assign in_display = in_display_q;
   assign line_len   = line_len_q;
   assign frame_len  = frame_len_q;
   assign sync_err   = sync_err_q;

`ifdef HVSYNC_DEC_ERRCNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = (sync_err_d && !(&err_cnt_q)) ? err_cnt_q + ERR_CNT_W'(1) : err_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_cnt_q <= '0;
      else        err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_hvsync_decoder.sv
// Self-checking bench for hvsync_decoder with a reduced raster so whole frames fit the run.
module tb_hvsync_decoder;

   localparam int HAS = 10, HA = 40, VAS = 3, VA = 12, LOCKN = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hs = 1'b1, vs = 1'b1;
   logic [10:0] pix_x, line_len;
   logic [8:0]  pix_y;
   logic        in_display, locked, sync_err;
   logic [9:0]  frame_len;
   logic [7:0]  err_cnt;

   always #5 clk = ~clk;

   hvsync_decoder #(
      .H_ACTIVE_START (HAS),
      .H_ACTIVE       (HA),
      .V_ACTIVE_START (VAS),
      .V_ACTIVE       (VA),
      .LOCK_LINES     (LOCKN)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .vga_h_sync (hs),
      .vga_v_sync (vs),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .in_display (in_display),
      .locked     (locked),
      .line_len   (line_len),
      .frame_len  (frame_len),
      .sync_err   (sync_err),
      .err_cnt    (err_cnt)
   );

   int checks = 0, errors = 0;

   // reference model: integer quantities, input sample history for the 3-clock event delay
   bit [4:1] mh, mv;
   int m_h, m_v, m_line, m_frame, m_state, m_match, m_err, m_errcnt, m_disp, m_px, m_py;
   bit pend_rst = 1'b0;

   int disp_cnt, err_pulses, fx, fy, lx, ly;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_h = 0; m_v = 0; m_line = 0; m_frame = 0; m_state = 0; m_match = 0;
      m_err = 0; m_errcnt = 0; m_disp = 0; m_px = 0; m_py = 0;
      mh = '1; mv = '1;
   endtask

   task automatic model_step();
      bit he, ve, lk, dsp;
      int nl, h_n, v_n, ln_n, fr_n, st_n, mt_n, er_n;
      he  = mh[4] && !mh[3];
      ve  = mv[4] && !mv[3];
      lk  = (m_state == 2);
      nl  = (m_h >= 2047) ? 2047 : m_h + 1;
      dsp = lk && m_h >= HAS && m_h < HAS + HA && m_v >= VAS && m_v < VAS + VA;
      h_n  = he ? 0 : nl;
      ln_n = he ? nl : m_line;
      v_n  = m_v;
      fr_n = m_frame;
      if (ve) begin
         v_n  = 0;
         fr_n = (m_v >= 1023) ? 1023 : m_v + 1;
      end else if (he) v_n = (m_v >= 1023) ? 1023 : m_v + 1;
      st_n = m_state; mt_n = m_match; er_n = 0;
      if (m_state == 0) begin
         if (he) begin st_n = 1; mt_n = 0; end
      end else if (m_state == 1) begin
         if (he) mt_n = (nl == m_line) ? ((m_match >= 255) ? 255 : m_match + 1) : 0;
         if (ve && m_match >= LOCKN) st_n = 2;
      end else if ((he && nl != m_line) || m_h == 2047 || m_v == 1023) begin
         st_n = 0; mt_n = 0; er_n = 1;
      end
      m_disp = dsp;
      m_px   = dsp ? m_h - HAS : 0;
      m_py   = dsp ? m_v - VAS : 0;
      m_h = h_n; m_v = v_n; m_line = ln_n; m_frame = fr_n;
      m_state = st_n; m_match = mt_n; m_err = er_n;
`ifdef HVSYNC_DEC_ERRCNT_EN
      if (er_n == 1 && m_errcnt < 255) m_errcnt++;
`endif
      mh = {mh[3:1], hs};
      mv = {mv[3:1], vs};
   endtask

   // one clock: model follows the edge, outputs compared on the falling edge, then new inputs
   task automatic tick(input logic h, input logic v);
      logic [51:0] act, exp;
      @(posedge clk);
      if (!rst_n) model_reset(); else model_step();
      if (pend_rst) begin
         #2 rst_n = 1'b0;
         pend_rst = 1'b0;
      end
      @(negedge clk);
      if (!rst_n) model_reset();
      act = {pix_x, pix_y, in_display, locked, line_len, frame_len, sync_err, err_cnt};
      exp = {11'(m_px), 9'(m_py), 1'(m_disp), 1'(m_state == 2), 11'(m_line),
             10'(m_frame), 1'(m_err), 8'(m_errcnt)};
      chk($sformatf("cycle@%0t", $time), 64'(act), 64'(exp));
      if (in_display) begin
         if (disp_cnt == 0) begin fx = pix_x; fy = pix_y; end
         lx = pix_x; ly = pix_y;
         disp_cnt++;
      end
      if (sync_err) err_pulses++;
      hs = h;
      vs = v;
   endtask

   task automatic run_frame(input int L, input int hw, input int F, input int short_line, input int delta);
      disp_cnt = 0; err_pulses = 0; fx = -1; fy = -1; lx = -1; ly = -1;
      for (int j = 0; j < F; j++) begin
         int len;
         len = (j == short_line) ? L + delta : L;
         for (int c = 0; c < len; c++) tick((c < hw) ? 1'b0 : 1'b1, (j == 0) ? 1'b0 : 1'b1);
      end
   endtask

   typedef struct {
      int L; int hw; int F;
      int exp_line; int exp_frame; int exp_locked; int exp_disp;
   } vec_t;

   vec_t vt[3];
   int   exp_err;

   initial begin
      vt[0] = '{64,  8, 20, 64, 20, 1, HA * VA};
      vt[1] = '{56,  4, 16, 56, 16, 1, HA * VA};
      vt[2] = '{72, 12, 24, 72, 24, 1, HA * VA};

      model_reset();
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
      chk("rst_locked", 64'(locked), 0);
      chk("rst_line_len", 64'(line_len), 0);
      chk("rst_frame_len", 64'(frame_len), 0);
      chk("rst_display", 64'({pix_x, pix_y, in_display}), 0);
      chk("rst_sync_err", 64'(sync_err), 0);
      rst_n = 1'b1;

      foreach (vt[i]) begin
         for (int f = 0; f < 3; f++) run_frame(vt[i].L, vt[i].hw, vt[i].F, -1, 0);
         chk("tbl_line_len", 64'(line_len), 64'(vt[i].exp_line));
         chk("tbl_frame_len", 64'(frame_len), 64'(vt[i].exp_frame));
         chk("tbl_locked", 64'(locked), 64'(vt[i].exp_locked));
         chk("tbl_disp_cycles", 64'(disp_cnt), 64'(vt[i].exp_disp));
         chk("tbl_first_px", 64'({fx[10:0], fy[8:0]}), 0);
         chk("tbl_last_px", 64'({lx[10:0], ly[8:0]}), 64'({11'(HA - 1), 9'(VA - 1)}));
      end

      // asynchronous reset in the middle of a locked frame
      run_frame(72, 12, 10, -1, 0);
      for (int i = 0; i < 20; i++) tick(1'b1, 1'b1);
      chk("pre_rst_locked", 64'(locked), 1);
      pend_rst = 1'b1;
      tick(1'b1, 1'b1);
      chk("midrst_locked", 64'(locked), 0);
      chk("midrst_outputs", 64'({pix_x, pix_y, in_display, line_len, frame_len, sync_err, err_cnt}), 0);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
      rst_n = 1'b1;
      err_pulses = 0;
      for (int i = 0; i < 30; i++) tick(1'b1, 1'b1);
      chk("post_rst_no_err", 64'(err_pulses), 0);
      chk("post_rst_no_hevt", 64'(line_len), 0);

      // three forced unlocks by a shortened line
      run_frame(64, 8, 20, -1, 0);
      run_frame(64, 8, 20, -1, 0);
      chk("err_pre_locked", 64'(locked), 1);
      for (int k = 0; k < 3; k++) begin
         run_frame(64, 8, 20, 5, -1);
         chk("short_err_pulses", 64'(err_pulses), 1);
         chk("short_unlocked", 64'(locked), 0);
         chk("short_line_len", 64'(line_len), 64);
         run_frame(64, 8, 20, -1, 0);
         chk("short_relocked", 64'(locked), 1);
      end
`ifdef HVSYNC_DEC_ERRCNT_EN
      exp_err = 3;
`else
      exp_err = 0;
`endif
      chk("err_cnt_after_3", 64'(err_cnt), 64'(exp_err));

      // hsync stuck high while locked
      err_pulses = 0;
      for (int i = 0; i < 2100; i++) tick(1'b1, 1'b1);
      chk("hold_err_pulses", 64'(err_pulses), 1);
      chk("hold_unlocked", 64'(locked), 0);
      chk("hold_line_len", 64'(line_len), 64);
      run_frame(64, 8, 20, -1, 0);
      run_frame(64, 8, 20, -1, 0);
      chk("hold_relocked", 64'(locked), 1);

      // randomized geometry and glitches, checked cycle by cycle against the model
      for (int f = 0; f < 12; f++) begin
         int L, hw, F, sl, d;
         L  = int'($urandom_range(80, 52));
         hw = int'($urandom_range(10, 2));
         F  = int'($urandom_range(24, 16));
         sl = ($urandom_range(2, 0) == 0) ? int'($urandom_range(F - 1, 1)) : -1;
         d  = int'($urandom_range(6, 0)) - 3;
         run_frame(L, hw, F, sl, d);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
